// File: rtl/id_ex_skid.sv
// ID->EX stage: two-entry skid buffer, one edge of latency; up_ready_out is registered and falls only when both entries are held.
// ID_EX_STAT_EN adds stall/bubble cycle counters (cleared by reset only).
module id_ex_skid #(
   parameter int DATA_W = 140
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              up_valid_in,
   output logic              up_ready_out,
   input  logic [DATA_W-1:0] up_data_in,
   output logic              dn_valid_out,
   input  logic              dn_ready_in,
   output logic [DATA_W-1:0] dn_data_out,
   output logic [1:0]        occupancy_out
`ifdef ID_EX_STAT_EN
   ,
   output logic [31:0]       stall_cnt_out,
   output logic [31:0]       bubble_cnt_out
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main_dat;
   logic [DATA_W-1:0] r_skid_dat;
   logic              w_push;
   logic              w_pop;
   logic              w_ld_main_up;
   logic              w_ld_main_skid;
   logic              w_ld_skid;

   // State alone defines occupancy, so ready/valid come straight from flops.
   assign up_ready_out  = (r_state != ST_FULL);
   assign dn_valid_out  = (r_state != ST_EMPTY);
   assign occupancy_out = r_state;
   assign dn_data_out   = dn_valid_out ? r_main_dat : '0;

   assign w_push = up_valid_in & up_ready_out & rdy_in;
   assign w_pop  = dn_valid_out & dn_ready_in & rdy_in;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_up   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush_in) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_nxt  = ST_ONE;
                  w_ld_main_up = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_ld_main_up = 1'b1;
               end else if (w_push) begin
                  w_state_nxt = ST_FULL;
                  w_ld_skid   = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_state_nxt    = ST_ONE;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_main_dat <= '0;
         r_skid_dat <= '0;
      end else begin
         if (w_ld_main_up) begin
            r_main_dat <= up_data_in;
         end else if (w_ld_main_skid) begin
            r_main_dat <= r_skid_dat;
         end
         if (w_ld_skid) begin
            r_skid_dat <= up_data_in;
         end
      end
   end

`ifdef ID_EX_STAT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_bubble_cnt;

   assign stall_cnt_out  = r_stall_cnt;
   assign bubble_cnt_out = r_bubble_cnt;

   // Counting ignores flush on purpose: a flushed cycle still stalled or bubbled.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else if (rdy_in) begin
         if (dn_valid_out && !dn_ready_in) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (!dn_valid_out) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed and random checks of id_ex_skid against a queue-based reference model.
module tb_id_ex_skid;
   localparam int W = 140;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b1;
   logic         rdy_in = 1'b1;
   logic         flush_in = 1'b0;
   logic         up_valid_in = 1'b0;
   logic         up_ready_out;
   logic [W-1:0] up_data_in = '0;
   logic         dn_valid_out;
   logic         dn_ready_in = 1'b0;
   logic [W-1:0] dn_data_out;
   logic [1:0]   occupancy_out;
`ifdef ID_EX_STAT_EN
   logic [31:0]  stall_cnt_out;
   logic [31:0]  bubble_cnt_out;
`endif

   id_ex_skid #(.DATA_W(W)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .flush_in      (flush_in),
      .up_valid_in   (up_valid_in),
      .up_ready_out  (up_ready_out),
      .up_data_in    (up_data_in),
      .dn_valid_out  (dn_valid_out),
      .dn_ready_in   (dn_ready_in),
      .dn_data_out   (dn_data_out),
      .occupancy_out (occupancy_out)
`ifdef ID_EX_STAT_EN
      ,
      .stall_cnt_out (stall_cnt_out),
      .bubble_cnt_out(bubble_cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad = 0;

   logic [W-1:0] mq[$];       // model: held entries, oldest first
   logic [W-1:0] exp_del[$];  // model: payloads execute should have taken
   logic [W-1:0] got[$];      // payloads observed leaving the DUT
   int unsigned  m_stall = 0;
   int unsigned  m_bubble = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic uv, input logic [W-1:0] ud, input logic dr,
                      input logic rd, input logic fl, input logic rs);
      int  sz;
      logic mpush, mpop;
      up_valid_in = uv;
      up_data_in  = ud;
      dn_ready_in = dr;
      rdy_in      = rd;
      flush_in    = fl;
      rst_in      = rs;
      @(negedge clk_in);
      if (!rs && dn_valid_out && dr && rd) got.push_back(dn_data_out);
      @(posedge clk_in);
      sz    = mq.size();
      mpush = uv && (sz < 2) && rd;
      mpop  = (sz > 0) && dr && rd;
      if (rs) begin
         mq.delete();
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         if (rd) begin
            if (sz > 0 && !dr) m_stall++;
            if (sz == 0) m_bubble++;
         end
         if (mpop) exp_del.push_back(mq[0]);
         if (fl) begin
            mq.delete();
         end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back(ud);
         end
      end
      #1;
      chk("dn_valid", W'(dn_valid_out), W'(mq.size() > 0));
      chk("dn_data", dn_data_out, (mq.size() > 0) ? mq[0] : '0);
      chk("up_ready", W'(up_ready_out), W'(mq.size() < 2));
      chk("occupancy", W'(occupancy_out), W'(mq.size()));
`ifdef ID_EX_STAT_EN
      chk("stall_cnt", W'(stall_cnt_out), W'(m_stall));
      chk("bubble_cnt", W'(bubble_cnt_out), W'(m_bubble));
`endif
   endtask

   task automatic check_got(input string tag);
      chk({tag, "_count"}, W'(got.size()), W'(exp_del.size()));
      for (int i = 0; i < got.size() && i < exp_del.size(); i++)
         chk({tag, "_order"}, got[i], exp_del[i]);
   endtask

   task automatic do_reset();
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
      got.delete();
      exp_del.delete();
   endtask

   initial begin
      logic [159:0] r;
      logic         ready_dropped;

      // Reset state
      do_reset();
      chk("rst_valid", W'(dn_valid_out), '0);
      chk("rst_data", dn_data_out, '0);
      chk("rst_ready", W'(up_ready_out), W'(1));
      chk("rst_occ", W'(occupancy_out), '0);

      // Single push then pop
      cyc(1'b1, W'(1), 1'b1, 1'b1, 1'b0, 1'b0);
      chk("single_valid", W'(dn_valid_out), W'(1));
      chk("single_data", dn_data_out, W'(1));
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("single_occ_after", W'(occupancy_out), '0);

      // Back-to-back stream 1..8
      do_reset();
      ready_dropped = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, W'(i), 1'b1, 1'b1, 1'b0, 1'b0);
         if (!up_ready_out) ready_dropped = 1'b1;
      end
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stream_ready_held", W'(ready_dropped), '0);
      chk("stream_count", W'(got.size()), W'(8));
      for (int i = 0; i < got.size(); i++) chk("stream_data", got[i], W'(i + 1));

      // Back-pressure: 1,2 accepted, 3 waits
      do_reset();
      cyc(1'b1, W'(1), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, W'(2), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bp_occ_full", W'(occupancy_out), W'(2));
      chk("bp_ready_low", W'(up_ready_out), '0);
      cyc(1'b1, W'(3), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bp_occ_still", W'(occupancy_out), W'(2));
      for (int i = 0; i < 4; i++) cyc((i < 2), W'(3), 1'b1, 1'b1, 1'b0, 1'b0);
      chk("bp_count", W'(got.size()), W'(3));
      for (int i = 0; i < got.size(); i++) chk("bp_data", got[i], W'(i + 1));

      // Flush while full, concurrent push of 9 dropped
      do_reset();
      cyc(1'b1, W'(1), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, W'(2), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, W'(9), 1'b0, 1'b1, 1'b1, 1'b0);
      chk("flush_occ", W'(occupancy_out), '0);
      chk("flush_data", dn_data_out, '0);
      chk("flush_ready", W'(up_ready_out), W'(1));
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("flush_none_delivered", W'(got.size()), '0);

      // Global freeze
      do_reset();
      cyc(1'b1, W'(5), 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, W'(6), 1'b1, 1'b0, 1'b0, 1'b0);
         chk("freeze_occ", W'(occupancy_out), W'(1));
         chk("freeze_data", dn_data_out, W'(5));
      end
      chk("freeze_no_pop", W'(got.size()), '0);
      cyc(1'b1, W'(6), 1'b1, 1'b1, 1'b0, 1'b0);
      chk("thaw_data", dn_data_out, W'(6));
      chk("thaw_pop", W'(got.size()), W'(1));

`ifdef ID_EX_STAT_EN
      // Counters: 4 empty cycles (last one pushes), 2 stalled, flush under freeze
      do_reset();
      for (int i = 0; i < 4; i++) cyc((i == 3), W'(7), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("stat_bubble", W'(bubble_cnt_out), W'(4));
      chk("stat_stall", W'(stall_cnt_out), W'(2));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stat_flush_occ", W'(occupancy_out), '0);
      chk("stat_bubble_kept", W'(bubble_cnt_out), W'(4));
      chk("stat_stall_kept", W'(stall_cnt_out), W'(2));
`endif

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cyc($urandom_range(0, 3) != 0, r[W-1:0], $urandom_range(0, 2) != 0,
             $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
             $urandom_range(0, 399) == 0);
      end
      check_got("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
